stage_fetch_wide: RTL
=====================

Name: stage_fetch_wide

Overview:
- Parametrised next-generation fetch stage. Fetches an aligned bundle of FETCH_WIDTH instructions per cycle from the iCache subsystem and queries the branch predictor for the first conditional branch.
- Delivers the bundle through a registered valid/ready output slot to the instruction buffer.
- Adds three behaviours over the previous fetch stage: misaligned-PC entry, lane masking after a predicted-taken branch, and an explicit stall FSM with a miss-cycle performance counter.
- Sits between the iCache subsystem/branch predictor and the instruction buffer.

Parameters:
- FETCH_WIDTH, 4, instructions per bundle; power of two, 2..8.
- WORDS_PER_LINE, 2, 32-bit words per iCache read line; divides FETCH_WIDTH.
- NUM_LINES, FETCH_WIDTH/WORDS_PER_LINE, derived; iCache read ports used.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- read_addrs  out  I_ADDR_PACKET[NUM_LINES-1:0]  line read requests.
- cache_data  in  CACHE_DATA[NUM_LINES-1:0]  same-cycle line data plus valid.
- bp_request  out  BP_PREDICT_REQUEST  predict query (valid, pc).
- bp_response  in  BP_PREDICT_RESPONSE  same-cycle taken/target/ghr_snapshot.
- ib_ready  in  1  IB can accept FETCH_WIDTH entries this cycle.
- out_valid  out  1  output slot holds a bundle.
- out_lane_valid  out  FETCH_WIDTH  per-lane valid mask of the held bundle.
- fetch_packet  out  FETCH_PACKET[FETCH_WIDTH-1:0]  held bundle.
- mispredict  in  1  redirect from retire.
- pc_override  in  32  redirect target.
- miss_cycles  out  32  count of cycles spent in MISS.

Behaviour:
- Bundle geometry:
  - base = PC with low log2(FETCH_WIDTH)+2 bits cleared; start lane s = PC[log2(FETCH_WIDTH)+1:2].
  - read_addrs[k].addr = base + k*WORDS_PER_LINE*4.
  - Line k is needed iff it contains any lane >= s.
  - Lane i is word i mod WORDS_PER_LINE of line i / WORDS_PER_LINE.
- lines_ok = every needed line has cache_data.valid = 1. Unneeded lines are ignored.
- Branch scan:
  - b = lowest lane >= s whose opcode is RV32_BRANCH.
  - bp_request.valid = 1 only in a capture cycle with a branch present; pc = base + 4*b. Otherwise bp_request is zero.
- capture = lines_ok && (!out_valid || ib_ready) && !mispredict.
- Lane mask at capture:
  - lane valid iff i >= s and (no predicted-taken branch, or i <= b).
  - Lane b gets is_branch = 1 and bp_* fields from bp_response. All other lanes get is_branch = 0 and zero bp_* fields.
  - Every lane gets pc = base + 4*i and inst.
- Next PC:
  - mispredict -> pc_override.
  - capture with branch taken -> bp_response.target.
  - capture otherwise -> base + 4*FETCH_WIDTH.
  - Otherwise hold. Any alignment is allowed for the redirect and target PCs.
- Output slot:
  - out_valid sets on capture.
  - Clears when (out_valid && ib_ready && !capture) or on mispredict.
  - Contents are stable while out_valid && !ib_ready.
  - A simultaneous drain and capture replaces the contents with no bubble.
- FSM (state updated every cycle from the same-cycle conditions):
  - RUN: requests issued.
    - out_valid && !ib_ready -> HOLD.
    - !lines_ok -> MISS.
  - HOLD: read_addrs.valid = 0.
    - ib_ready -> RUN (captures if lines_ok).
  - MISS: requests reissued every cycle; miss_cycles increments once per MISS cycle, saturating at 32'hFFFFFFFF.
    - lines_ok -> RUN.
  - mispredict from any state -> RUN next cycle, with requests at pc_override.
- read_addrs[k].valid = needed(k) && state != HOLD && !mispredict.
- Reset (async, reset = 0):
  - PC = RESET_PC, state = RUN, out_valid = 0, out_lane_valid = 0, fetch_packet = 0, miss_cycles = 0.
  - The first requests go out in the first cycle after deassertion.
  - Reset mid-stall discards the held bundle.

Test Plan:
- Straight line, FETCH_WIDTH=4, PC=0, all lines valid, ib_ready=1 -> bundles at PC 0x0, 0x10, 0x20 on consecutive cycles; out_lane_valid = 4'b1111.
- Misaligned redirect: mispredict with pc_override=0x18 -> next bundle base 0x10, out_lane_valid = 4'b1100, read_addrs[0].valid = 0, then PC 0x20.
- Taken branch in lane 1 at base 0x40, target 0x100 -> bp_request.pc = 0x44, lane1 is_branch = 1, mask = 4'b0011, next base 0x100.
- Miss: line 1 invalid for 3 cycles -> state MISS for 3 cycles, miss_cycles = 3, no capture, then capture with an unchanged PC.
- Backpressure: ib_ready=0 for 2 cycles with out_valid=1 -> fetch_packet stable, read_addrs.valid = 0; ib_ready=1 -> drain and capture in the same cycle, out_valid stays 1.
- Async reset asserted during HOLD -> out_valid = 0 immediately; after release, requests at RESET_PC.

Source files
------------

// File: rtl/stage_fetch_wide_if.sv
// Fetch-stage shared types, plus the output-slot bundle interface toward the instruction buffer.
// Interface is wires only: zero latency; ib_ready is the consumer's backpressure into the slot.
package stage_fetch_pkg;
    localparam logic [6:0] RV32_BRANCH = 7'b1100011;
    localparam int GHR_W = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } i_addr_packet_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } bp_predict_request_t;

    typedef struct packed {
        logic             taken;
        logic [31:0]      target;
        logic [GHR_W-1:0] ghr_snapshot;
    } bp_predict_response_t;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic             is_branch;
        logic             bp_taken;
        logic [31:0]      bp_target;
        logic [GHR_W-1:0] bp_ghr;
    } fetch_packet_t;
endpackage

interface stage_fetch_wide_if #(
    parameter int FETCH_WIDTH = 4
);
    import stage_fetch_pkg::*;

    logic                                out_valid;
    logic                                ib_ready;
    logic          [FETCH_WIDTH-1:0]     out_lane_valid;
    fetch_packet_t [FETCH_WIDTH-1:0]     fetch_packet;

    modport master (output out_valid, output out_lane_valid, output fetch_packet, input ib_ready);
    modport slave  (input out_valid, input out_lane_valid, input fetch_packet, output ib_ready);
endinterface

// File: rtl/stage_fetch_wide.sv
// Wide fetch: aligned FETCH_WIDTH bundle per cycle, first-branch prediction, lane masking, miss counter.
// One-cycle latency into a registered output slot; slot holds while !ib_ready and drain+capture is bubble-free.
module stage_fetch_wide
    import stage_fetch_pkg::*;
#(
    parameter int          FETCH_WIDTH    = 4,
    parameter int          WORDS_PER_LINE = 2,
    parameter int          NUM_LINES      = FETCH_WIDTH / WORDS_PER_LINE,
    parameter logic [31:0] RESET_PC       = 32'h0
) (
    input  logic                                          clock,
    input  logic                                          reset,
    output i_addr_packet_t [NUM_LINES-1:0]                read_addrs,
    input  logic [NUM_LINES-1:0]                          cache_valid,
    input  logic [NUM_LINES-1:0][WORDS_PER_LINE-1:0][31:0] cache_data,
    output bp_predict_request_t                           bp_request,
    input  bp_predict_response_t                          bp_response,
    stage_fetch_wide_if.master                            ib,
    input  logic                                          mispredict,
    input  logic [31:0]                                   pc_override,
    output logic [31:0]                                   miss_cycles
);
    localparam int LW  = $clog2(FETCH_WIDTH);
    localparam int OFF = LW + 2;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_MISS = 2'd2;

    logic [1:0]                        state, state_nxt;
    logic [31:0]                       pc, base;
    logic [LW-1:0]                     start_lane, br_lane;
    logic                              br_found, pred_taken, lines_ok, capture;
    logic [NUM_LINES-1:0]              line_needed;
    logic [FETCH_WIDTH-1:0][31:0]      lane_inst;
    logic [FETCH_WIDTH-1:0]            lane_mask;
    fetch_packet_t [FETCH_WIDTH-1:0]   lane_pkt;
    logic                              unused_pc_bits;

    assign base           = {pc[31:OFF], {OFF{1'b0}}};
    assign start_lane     = pc[OFF-1:2];
    assign unused_pc_bits = ^pc[1:0];

    // A line is only fetched if it holds a lane at or past the entry point.
    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        assign line_needed[k]      = (((k + 1) * WORDS_PER_LINE) - 1) >= int'(start_lane);
        assign read_addrs[k].valid = line_needed[k] && (state != ST_HOLD) && !mispredict;
        assign read_addrs[k].addr  = base + 32'(k * WORDS_PER_LINE * 4);
    end

    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
        assign lane_inst[i] = cache_data[i / WORDS_PER_LINE][i % WORDS_PER_LINE];
    end

    assign lines_ok   = &(cache_valid | ~line_needed);
    assign capture    = lines_ok && (!ib.out_valid || ib.ib_ready) && !mispredict;
    assign pred_taken = br_found && bp_response.taken;

    always_comb begin
        br_found = 1'b0;
        br_lane  = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (i >= int'(start_lane) && lane_inst[i][6:0] == RV32_BRANCH) begin
                br_found = 1'b1;
                br_lane  = i[LW-1:0];
            end
        end
    end

    always_comb begin
        bp_request = '0;
        if (capture && br_found) begin
            bp_request.valid = 1'b1;
            bp_request.pc    = base + 32'({br_lane, 2'b00});
        end
    end

    // Lanes past a predicted-taken branch are fetched but never delivered.
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_mask[i]     = (i >= int'(start_lane)) && (!pred_taken || i <= int'(br_lane));
            lane_pkt[i]      = '0;
            lane_pkt[i].pc   = base + 32'(4 * i);
            lane_pkt[i].inst = lane_inst[i];
            if (br_found && i == int'(br_lane)) begin
                lane_pkt[i].is_branch = 1'b1;
                lane_pkt[i].bp_taken  = bp_response.taken;
                lane_pkt[i].bp_target = bp_response.target;
                lane_pkt[i].bp_ghr    = bp_response.ghr_snapshot;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (mispredict) begin
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ib.out_valid && !ib.ib_ready) state_nxt = ST_HOLD;
                    else if (!lines_ok)               state_nxt = ST_MISS;
                end
                ST_HOLD: if (ib.ib_ready) state_nxt = ST_RUN;
                ST_MISS: if (lines_ok)    state_nxt = ST_RUN;
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc                <= RESET_PC;
            state             <= ST_RUN;
            ib.out_valid      <= 1'b0;
            ib.out_lane_valid <= '0;
            ib.fetch_packet   <= '0;
            miss_cycles       <= '0;
        end else begin
            state <= state_nxt;
            if (mispredict)
                pc <= pc_override;
            else if (capture)
                pc <= pred_taken ? bp_response.target : base + 32'(4 * FETCH_WIDTH);

            if (capture) begin
                ib.out_valid      <= 1'b1;
                ib.out_lane_valid <= lane_mask;
                ib.fetch_packet   <= lane_pkt;
            end else if (mispredict || ib.ib_ready) begin
                ib.out_valid <= 1'b0;
            end

            if (state == ST_MISS && miss_cycles != 32'hFFFF_FFFF)
                miss_cycles <= miss_cycles + 32'd1;
        end
    end
endmodule
